ex_mem_bf2: RTL and testbench

EX stage plus EX/MEM pipeline register (BF2). Consumes the registered ID/EX bundle from BF1, executes the ALU operation and computes the branch target, then registers the results for the MEM stage. Supports memory-side stall, flush/bubble insertion, and an iterative 32-cycle multiply. The multiply back-pressures BF1 through busy_BF2.

---
 rtl/ex_bf2_pkg.sv | 46 ++++
 rtl/ex_mem_bf2_mul.sv | 53 +++++
 rtl/ex_mem_bf2.sv | 188 ++++++++++++++++++
 tb/tb_ex_mem_bf2.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_bf2_pkg.sv
// Shared types and constants for the EX stage / EX-MEM register (BF2).
// Funct codes, ALU-op and FSM encodings, and the registered EX/MEM bundle.
package ex_bf2_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int PC_W_DEF       = 8;
  localparam int MUL_CYCLES_DEF = 32;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  typedef enum logic {
    ALU_ADD   = 1'b0,
    ALU_FUNCT = 1'b1
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]            wb;
    logic [2:0]            m;
    logic [DATA_W_DEF-1:0] alu;
    logic                  zero;
    logic [DATA_W_DEF-1:0] wdata;
    logic [4:0]            wreg;
    logic [PC_W_DEF-1:0]   bt;
    logic                  valid;
  } ex_mem_t;

  function automatic logic is_mul_op(
    input logic       alu_op,
    input logic       alu_src,
    input logic [5:0] funct
  );
    return alu_op && !alu_src && (funct == FUNCT_MUL);
  endfunction

endpackage

// File: rtl/ex_mem_bf2_mul.sv
// Iterative shift-add multiplier: one multiplier bit consumed per cycle.
// Product holds the low DATA_W bits; it is stable whenever hold_i is high.
module mul_seq_32 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic              hold_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] product_o
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (clear_i) begin
      acc_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
    end else if (start_i) begin
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
    end else if (!hold_i) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign product_o = acc_q;

endmodule

// File: rtl/ex_mem_bf2.sv
// EX stage plus EX/MEM register: single-cycle ALU, branch target and a
// 32-iteration multiply that back-pressures BF1 through busy_BF2.
module ex_mem_bf2
  import ex_bf2_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PC_W       = PC_W_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic              clk_BF2,
  input  logic              rst_BF2,
  input  logic              valid_BF2_IN,
  input  logic [1:0]        WB_BF2_IN,
  input  logic [2:0]        M_BF2_IN,
  input  logic              RegDst_BF2_IN,
  input  logic              ALUOp_BF2_IN,
  input  logic              ALUSrc_BF2_IN,
  input  logic [PC_W-1:0]   nextInst_BF2_IN,
  input  logic [DATA_W-1:0] regData1_BF2_IN,
  input  logic [DATA_W-1:0] regData2_BF2_IN,
  input  logic [DATA_W-1:0] rdshfunct_BF2_IN,
  input  logic [4:0]        rd_BF2_IN,
  input  logic [4:0]        rt_BF2_IN,
  input  logic              stall_BF2_IN,
  input  logic              flush_BF2_IN,
  output logic [1:0]        WB_BF2,
  output logic [2:0]        M_BF2,
  output logic [DATA_W-1:0] aluResult_BF2,
  output logic              zero_BF2,
  output logic [DATA_W-1:0] writeData_BF2,
  output logic [4:0]        writeReg_BF2,
  output logic [PC_W-1:0]   branchTarget_BF2,
  output logic              valid_BF2,
  output logic              busy_BF2
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  logic [5:0]        funct;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] product;
  logic              mul_req;
  logic              mul_start;
  logic              mul_hold;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ex_mem_t           out_q, out_d;
  ex_mem_t           ctl_q, ctl_d;
  ex_mem_t           single;

  assign funct   = rdshfunct_BF2_IN[5:0];
  assign alu_op  = alu_op_e'(ALUOp_BF2_IN);
  assign op_a    = regData1_BF2_IN;
  assign op_b    = ALUSrc_BF2_IN ? rdshfunct_BF2_IN
                                 : regData2_BF2_IN;
  assign mul_req = valid_BF2_IN &&
                   is_mul_op(ALUOp_BF2_IN, ALUSrc_BF2_IN, funct);

  always_comb begin
    alu_res = '0;
    if (alu_op == ALU_ADD) begin
      alu_res = op_a + op_b;
    end else begin
      unique case (1'b1)
        (funct == FUNCT_ADD): alu_res = op_a + op_b;
        (funct == FUNCT_SUB): alu_res = op_a - op_b;
        (funct == FUNCT_AND): alu_res = op_a & op_b;
        (funct == FUNCT_OR):  alu_res = op_a | op_b;
        (funct == FUNCT_SLT): begin
          alu_res = {{(DATA_W-1){1'b0}},
                     ($signed(op_a) < $signed(op_b))};
        end
        default: alu_res = '0;
      endcase
    end
  end

  always_comb begin
    single       = '0;
    single.wb    = WB_BF2_IN;
    single.m     = M_BF2_IN;
    single.alu   = alu_res;
    single.zero  = (alu_res == '0);
    single.wdata = regData2_BF2_IN;
    single.wreg  = RegDst_BF2_IN ? rd_BF2_IN : rt_BF2_IN;
    single.bt    = nextInst_BF2_IN + {funct, 2'b00};
    single.valid = 1'b1;
  end

  assign mul_start = (state_q == IDLE) && mul_req &&
                     !stall_BF2_IN && !flush_BF2_IN;
  assign mul_hold  = stall_BF2_IN || (state_q != MUL);

  mul_seq_32 #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk       (clk_BF2),
    .rst       (rst_BF2),
    .start_i   (mul_start),
    .clear_i   (flush_BF2_IN),
    .hold_i    (mul_hold),
    .a_i       (op_a),
    .b_i       (op_b),
    .product_o (product)
  );

  always_ff @(posedge clk_BF2 or posedge rst_BF2) begin
    if (rst_BF2) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ctl_q   <= ctl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_BF2_IN) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!stall_BF2_IN) begin
      unique case (state_q)
        IDLE: begin
          if (mul_req) begin
            state_d = MUL;
            cnt_d   = '0;
          end
        end
        MUL: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MUL_CYCLES - 1)) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The mul's control bits ride alongside the multiplier until DONE.
  assign ctl_d = mul_start ? single : ctl_q;

  always_comb begin
    out_d = out_q;
    if (flush_BF2_IN) begin
      out_d = '0;
    end else if (!stall_BF2_IN) begin
      unique case (state_q)
        IDLE: out_d = (valid_BF2_IN && !mul_req) ? single : '0;
        MUL:  out_d = '0;
        DONE: begin
          out_d       = ctl_q;
          out_d.alu   = product;
          out_d.zero  = (product == '0);
          out_d.valid = 1'b1;
        end
        default: out_d = '0;
      endcase
    end
  end

  assign busy_BF2 = stall_BF2_IN || (state_q == MUL) ||
                    ((state_q == IDLE) && mul_req);

  assign WB_BF2           = out_q.wb;
  assign M_BF2            = out_q.m;
  assign aluResult_BF2    = out_q.alu;
  assign zero_BF2         = out_q.zero;
  assign writeData_BF2    = out_q.wdata;
  assign writeReg_BF2     = out_q.wreg;
  assign branchTarget_BF2 = out_q.bt;
  assign valid_BF2        = out_q.valid;

endmodule

// File: tb/tb_ex_mem_bf2.sv
// Scoreboard bench for ex_mem_bf2: directed cases plus random traffic
// checked against a behavioural model of the EX stage.
module tb_ex_mem_bf2;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        regdst, aluop, alusrc;
    logic [7:0]  ni;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rd, rt;
  } instr_t;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic [7:0]  bt;
  } exp_t;

  logic        clk = 0, rst = 1;
  logic        valid_in = 0, regdst = 0, aluop = 0, alusrc = 0;
  logic [1:0]  wb_in = 0;
  logic [2:0]  m_in = 0;
  logic [7:0]  ni = 0;
  logic [31:0] rd1 = 0, rd2 = 0, imm = 0;
  logic [4:0]  rd = 0, rt = 0;
  logic        stall = 0, flush = 0;
  logic [1:0]  wb_o;
  logic [2:0]  m_o;
  logic [31:0] alu_o, wdata_o;
  logic        zero_o, valid_o, busy_o;
  logic [4:0]  wreg_o;
  logic [7:0]  bt_o;

  int total = 0;
  int bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  ex_mem_bf2 dut (
    .clk_BF2 (clk), .rst_BF2 (rst),
    .valid_BF2_IN (valid_in), .WB_BF2_IN (wb_in),
    .M_BF2_IN (m_in), .RegDst_BF2_IN (regdst),
    .ALUOp_BF2_IN (aluop), .ALUSrc_BF2_IN (alusrc),
    .nextInst_BF2_IN (ni), .regData1_BF2_IN (rd1),
    .regData2_BF2_IN (rd2), .rdshfunct_BF2_IN (imm),
    .rd_BF2_IN (rd), .rt_BF2_IN (rt),
    .stall_BF2_IN (stall), .flush_BF2_IN (flush),
    .WB_BF2 (wb_o), .M_BF2 (m_o), .aluResult_BF2 (alu_o),
    .zero_BF2 (zero_o), .writeData_BF2 (wdata_o),
    .writeReg_BF2 (wreg_o), .branchTarget_BF2 (bt_o),
    .valid_BF2 (valid_o), .busy_BF2 (busy_o)
  );

  function automatic exp_t model(input instr_t t);
    exp_t e;
    logic [31:0] b, r;
    logic [7:0]  off;
    logic [5:0]  f;
    b = t.alusrc ? t.imm : t.rd2;
    f = t.imm[5:0];
    r = 0;
    if (!t.aluop) r = t.rd1 + b;
    else case (f)
      6'h20: r = t.rd1 + b;
      6'h22: r = t.rd1 - b;
      6'h24: r = t.rd1 & b;
      6'h25: r = t.rd1 | b;
      6'h2A: r = ($signed(t.rd1) < $signed(b)) ? 1 : 0;
      6'h18: r = t.alusrc ? 0 : t.rd1 * b;
      default: r = 0;
    endcase
    off     = {f, 2'b00};
    e.wb    = t.wb;
    e.m     = t.m;
    e.alu   = r;
    e.zero  = (r == 0);
    e.wdata = t.rd2;
    e.wreg  = t.regdst ? t.rd : t.rt;
    e.bt    = t.ni + off;
    return e;
  endfunction

  function automatic instr_t mk(
    input logic [1:0] w, input logic [2:0] mm,
    input logic rdst, input logic op, input logic src,
    input logic [7:0] n, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] i,
    input logic [4:0] d, input logic [4:0] s);
    instr_t t;
    t.wb = w; t.m = mm; t.regdst = rdst; t.aluop = op;
    t.alusrc = src; t.ni = n; t.rd1 = a; t.rd2 = b;
    t.imm = i; t.rd = d; t.rt = s;
    return t;
  endfunction

  function automatic instr_t rnd();
    instr_t t;
    logic [15:0] lo;
    logic [5:0]  f;
    t.wb = 2'($urandom); t.m = 3'($urandom);
    t.regdst = 1'($urandom); t.ni = 8'($urandom);
    t.rd = 5'($urandom); t.rt = 5'($urandom);
    t.aluop = ($urandom_range(0, 3) != 0);
    case ($urandom_range(0, 7))
      0: f = 6'h20; 1: f = 6'h22; 2: f = 6'h24;
      3: f = 6'h25; 4: f = 6'h2A; 5: f = 6'h18;
      default: f = 6'($urandom);
    endcase
    lo = {16'($urandom)};
    lo[5:0] = f;
    t.imm = {{16{lo[15]}}, lo};
    t.alusrc = t.aluop ? 1'b0 : 1'($urandom);
    t.rd1 = $urandom;
    t.rd2 = ($urandom_range(0, 3) == 0) ? t.rd1 : $urandom;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input instr_t t);
    wb_in = t.wb; m_in = t.m; regdst = t.regdst;
    aluop = t.aluop; alusrc = t.alusrc; ni = t.ni;
    rd1 = t.rd1; rd2 = t.rd2; imm = t.imm;
    rd = t.rd; rt = t.rt;
  endtask

  // Present until accepted (busy low before the edge), optional random stall.
  task automatic issue(input instr_t t, input bit rs);
    bit b, ok;
    ok = 0;
    drive(t);
    valid_in = 1;
    q.push_back(model(t));
    for (int c = 0; c < 400; c++) begin
      stall = rs ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      b = busy_o;
      @(posedge clk);
      #1;
      if (!b) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout act=busy exp=accepted");
    end
    valid_in = 0;
    stall = 0;
  endtask

  initial begin : monitor
    bit   held;
    exp_t e;
    forever begin
      @(posedge clk);
      held = stall && !flush;
      @(negedge clk);
      if (!rst && valid_o && !held) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid act=alu %h exp=none", alu_o);
        end else begin
          e = q.pop_front();
          if (wb_o !== e.wb || m_o !== e.m || alu_o !== e.alu ||
              zero_o !== e.zero || wdata_o !== e.wdata ||
              wreg_o !== e.wreg || bt_o !== e.bt) begin
            bad++;
            $display("FAIL sb act=%h/%h/%h/%b/%h/%h/%h exp=%h/%h/%h/%b/%h/%h/%h",
              wb_o, m_o, alu_o, zero_o, wdata_o, wreg_o, bt_o,
              e.wb, e.m, e.alu, e.zero, e.wdata, e.wreg, e.bt);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    instr_t t, a, b;
    int leaks;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_alu", alu_o, 0);
    chk("rst_busy", 32'(busy_o), 0);
    rst = 0;
    @(posedge clk); #1;

    t = mk(2'b10, 3'b000, 1, 1, 0, 8'h04, 5, 3, 32'h20, 9, 2);
    issue(t, 0);
    chk("add_alu", alu_o, 8);
    chk("add_wreg", 32'(wreg_o), 9);
    chk("add_zero", 32'(zero_o), 0);
    chk("add_valid", 32'(valid_o), 1);

    @(negedge clk); #2;
    rst = 1;
    #1;
    chk("arst_valid", 32'(valid_o), 0);
    chk("arst_alu", alu_o, 0);
    chk("arst_wb", 32'(wb_o), 0);
    chk("arst_wreg", 32'(wreg_o), 0);
    @(posedge clk); #1;
    rst = 0;

    t = mk(2'b11, 3'b010, 0, 0, 1, 8'h08, 32'h100, 32'hDEADBEEF,
           32'hFFFFFFFC, 7, 4);
    issue(t, 0);
    chk("lw_alu", alu_o, 32'hFC);
    chk("lw_wreg", 32'(wreg_o), 4);
    chk("lw_wdata", wdata_o, 32'hDEADBEEF);

    t = mk(2'b00, 3'b100, 0, 1, 0, 8'h10, 32'h55, 32'h55, 3, 1, 2);
    issue(t, 0);
    chk("beq_zero", 32'(zero_o), 1);
    chk("beq_bt", 32'(bt_o), 32'h1C);
    t.ni = 8'hFC; t.imm = 2;
    issue(t, 0);
    chk("bt_wrap", 32'(bt_o), 32'h04);

    t = mk(2'b11, 3'b111, 1, 1, 0, 8'h00, 9, 4, 32'h3F, 3, 1);
    issue(t, 0);
    chk("bad_funct_alu", alu_o, 0);
    chk("bad_funct_wb", 32'(wb_o), 3);

    // mul latency and busy profile
    t = mk(2'b10, 3'b001, 1, 1, 0, 8'h20, 7, 32'hFFFFFFFF,
           32'h18, 12, 13);
    drive(t); valid_in = 1;
    q.push_back(model(t));
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_%0d", k), 32'(busy_o),
          32'(k <= 33));
      @(posedge clk); #1;
      chk($sformatf("mul_valid_%0d", k), 32'(valid_o),
          32'(k == 34));
    end
    valid_in = 0;
    #1;
    chk("mul_result", alu_o, 32'hFFFFFFF9);
    chk("mul_busy_after", 32'(busy_o), 0);

    // stall for three edges during MUL delays the result by three
    t = mk(2'b01, 3'b010, 0, 1, 0, 8'h30, 32'h1234, 32'h10,
           32'h18, 1, 6);
    drive(t); valid_in = 1;
    q.push_back(model(t));
    for (int k = 1; k <= 37; k++) begin
      stall = (k >= 6 && k <= 8);
      @(negedge clk);
      chk($sformatf("stl_busy_%0d", k), 32'(busy_o),
          32'(k <= 36));
      @(posedge clk); #1;
      chk($sformatf("stl_valid_%0d", k), 32'(valid_o),
          32'(k == 37));
    end
    valid_in = 0; stall = 0;
    chk("stl_result", alu_o, 32'h12340);

    // flush aborts a multiply
    t = mk(2'b11, 3'b111, 1, 1, 0, 8'h00, 3, 5, 32'h18, 4, 4);
    drive(t); valid_in = 1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1; valid_in = 0;
    @(posedge clk); #1;
    flush = 0;
    #1;
    chk("flush_valid", 32'(valid_o), 0);
    chk("flush_busy", 32'(busy_o), 0);
    chk("flush_wb", 32'(wb_o), 0);
    leaks = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (valid_o) leaks++;
    end
    chk("flush_no_result", leaks, 0);

    // stall holds a single-cycle result
    a = mk(2'b10, 3'b000, 1, 1, 0, 8'h00, 40, 2, 32'h22, 5, 0);
    issue(a, 0);
    b = mk(2'b01, 3'b001, 1, 1, 0, 8'h00, 6, 9, 32'h25, 6, 0);
    drive(b); valid_in = 1; stall = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("stall_alu_hold", alu_o, 38);
    chk("stall_valid_hold", 32'(valid_o), 1);
    q.push_back(model(b));
    stall = 0;
    @(posedge clk); #1;
    valid_in = 0;
    chk("after_stall_alu", alu_o, 15);

    // flush beats stall
    drive(a); valid_in = 1; flush = 1; stall = 1;
    @(posedge clk); #1;
    flush = 0; stall = 0; valid_in = 0;
    chk("flush_stall_valid", 32'(valid_o), 0);
    chk("flush_stall_wb", 32'(wb_o), 0);

    for (int n = 0; n < 200; n++) begin
      issue(rnd(), 1);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    repeat (4) @(posedge clk);
    chk("sb_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
